// File: rtl/apb4_gpio_ext_pkg.sv
// rtl/apb4_gpio_ext_pkg.sv - register word indices and interrupt-type encoding for apb4_gpio_ext
package apb4_gpio_ext_pkg;

  // Word index into the register map (paddr[5:2])
  localparam logic [3:0] REG_PADDIR   = 4'h0;
  localparam logic [3:0] REG_PADIN    = 4'h1;
  localparam logic [3:0] REG_PADOUT   = 4'h2;
  localparam logic [3:0] REG_OUTSET   = 4'h3;
  localparam logic [3:0] REG_OUTCLR   = 4'h4;
  localparam logic [3:0] REG_OUTTGL   = 4'h5;
  localparam logic [3:0] REG_INTEN    = 4'h6;
  localparam logic [3:0] REG_INTTYPE0 = 4'h7;
  localparam logic [3:0] REG_INTTYPE1 = 4'h8;
  localparam logic [3:0] REG_INTSTAT  = 4'h9;
  localparam logic [3:0] REG_IOFCFG   = 4'hA;
  localparam logic [3:0] REG_DBNCEN   = 4'hB;
  localparam logic [3:0] REG_DBNCDIV  = 4'hC;
  localparam logic [3:0] REG_RAWIN    = 4'hD;

  typedef enum logic [1:0] {INT_RISE, INT_FALL, INT_HIGH, INT_LOW} int_type_e;

endpackage

// File: rtl/apb4_if.sv
// rtl/apb4_if.sv - APB4 slave bus bundle carrying clock and reset
interface apb4_if;
  logic        hclk;
  logic        hresetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave (
    input  hclk, hresetn, psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_gpio_ext_dbnc.sv
// rtl/apb4_gpio_ext_dbnc.sv - one pin's debounce counter and filtered level
module gpio_dbnc
  import apb4_gpio_ext_pkg::*;
#(
  parameter int CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic en,
  input  logic d,
  output logic q
);

  localparam int CW = $clog2(CNT + 1);

  logic [CW-1:0] cnt;

  // Counter climbs to CNT on ticks while d differs, then the next tick accepts d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      q   <= d;
    end else if (d == q) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CW'(CNT)) begin
        q   <= d;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb4_gpio_ext.sv
// rtl/apb4_gpio_ext.sv - APB4 GPIO with atomic output ops, debounce and sticky interrupts
module apb4_gpio_ext
  import apb4_gpio_ext_pkg::*;
#(
  parameter int GPIO_NUM  = 32,
  parameter int DBNC_CNT  = 4,
  parameter int DIV_WIDTH = 16
) (
  apb4_if.slave                apb4,
  input  logic [GPIO_NUM-1:0]  gpio_in_i,
  output logic [GPIO_NUM-1:0]  gpio_in_sync_o,
  output logic [GPIO_NUM-1:0]  gpio_out_o,
  output logic [GPIO_NUM-1:0]  gpio_dir_o,
  output logic [GPIO_NUM-1:0]  gpio_iof_o,
  output logic                 irq_o
);

  logic                 clk;
  logic                 rst_n;
  logic                 wr;
  logic [3:0]           idx;
  logic [GPIO_NUM-1:0]  wdata;
  logic [GPIO_NUM-1:0]  paddir, padout, inten, inttype0, inttype1, intstat, iofcfg, dbncen;
  logic [DIV_WIDTH-1:0] dbncdiv, pcnt;
  logic                 tick;
  logic [GPIO_NUM-1:0]  sync1, raw_sync, filt, filt_d, rise, fall, evt, clr;
  logic [31:0]          rdata;

  assign clk   = apb4.hclk;
  assign rst_n = apb4.hresetn;
  assign wr    = apb4.psel & apb4.penable & apb4.pwrite;
  assign idx   = apb4.paddr[5:2];
  assign wdata = apb4.pwdata[GPIO_NUM-1:0];

  assign apb4.pready  = 1'b1;
  assign apb4.pslverr = 1'b0;
  assign apb4.prdata  = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddir   <= '0;
      padout   <= '0;
      inten    <= '0;
      inttype0 <= '0;
      inttype1 <= '0;
      iofcfg   <= '0;
      dbncen   <= '0;
      dbncdiv  <= '0;
    end else if (wr) begin
      case (idx)
        REG_PADDIR:   paddir   <= wdata;
        REG_PADOUT:   padout   <= wdata;
        REG_OUTSET:   padout   <= padout | wdata;
        REG_OUTCLR:   padout   <= padout & ~wdata;
        REG_OUTTGL:   padout   <= padout ^ wdata;
        REG_INTEN:    inten    <= wdata;
        REG_INTTYPE0: inttype0 <= wdata;
        REG_INTTYPE1: inttype1 <= wdata;
        REG_IOFCFG:   iofcfg   <= wdata;
        REG_DBNCEN:   dbncen   <= wdata;
        REG_DBNCDIV:  dbncdiv  <= apb4.pwdata[DIV_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Compare with >= so a shrinking DBNCDIV can never leave the counter stranded above it
  assign tick = (pcnt >= dbncdiv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if ((wr && idx == REG_DBNCDIV) || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      raw_sync <= '0;
      filt_d   <= '0;
    end else begin
      sync1    <= gpio_in_i;
      raw_sync <= sync1;
      filt_d   <= filt;
    end
  end

  for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
    gpio_dbnc #(.CNT(DBNC_CNT)) u_dbnc (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .en   (dbncen[i]),
      .d    (raw_sync[i]),
      .q    (filt[i])
    );
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_comb begin
    evt = '0;
    for (int i = 0; i < GPIO_NUM; i++) begin
      case (int_type_e'({inttype1[i], inttype0[i]}))
        INT_RISE: evt[i] = rise[i];
        INT_FALL: evt[i] = fall[i];
        INT_HIGH: evt[i] = filt[i];
        INT_LOW:  evt[i] = ~filt[i];
        default:  evt[i] = 1'b0;
      endcase
    end
  end

  assign clr = (wr && idx == REG_INTSTAT) ? wdata : '0;

  // Set is OR-ed after the clear so a same-cycle event survives a W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intstat <= '0;
      irq_o   <= 1'b0;
    end else begin
      intstat <= (intstat & ~clr) | (evt & inten);
      irq_o   <= |(intstat & inten);
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_PADDIR:   rdata[GPIO_NUM-1:0]  = paddir;
      REG_PADIN:    rdata[GPIO_NUM-1:0]  = filt;
      REG_PADOUT:   rdata[GPIO_NUM-1:0]  = padout;
      REG_INTEN:    rdata[GPIO_NUM-1:0]  = inten;
      REG_INTTYPE0: rdata[GPIO_NUM-1:0]  = inttype0;
      REG_INTTYPE1: rdata[GPIO_NUM-1:0]  = inttype1;
      REG_INTSTAT:  rdata[GPIO_NUM-1:0]  = intstat;
      REG_IOFCFG:   rdata[GPIO_NUM-1:0]  = iofcfg;
      REG_DBNCEN:   rdata[GPIO_NUM-1:0]  = dbncen;
      REG_DBNCDIV:  rdata[DIV_WIDTH-1:0] = dbncdiv;
      REG_RAWIN:    rdata[GPIO_NUM-1:0]  = raw_sync;
      default: ;
    endcase
  end

  assign gpio_in_sync_o = filt;
  assign gpio_out_o     = padout;
  assign gpio_dir_o     = paddir;
  assign gpio_iof_o     = iofcfg;

endmodule

// File: tb/tb_apb4_gpio_ext.sv
// tb/tb_apb4_gpio_ext.sv - self-checking bench for apb4_gpio_ext (32-pin and 8-pin builds)
module tb_apb4_gpio_ext;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;
  logic        psel_a, psel_b, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] gin_a, sync_a, out_a, dir_a, iof_a;
  logic [7:0]  gin_b, sync_b, out_b, dir_b, iof_b;
  logic        irq_a, irq_b;
  logic [31:0] rd;
  logic        seen;
  vec_t        vecs[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  apb4_if bus_a();
  apb4_if bus_b();

  assign bus_a.hclk    = clk;
  assign bus_a.hresetn = rst_a_n;
  assign bus_a.psel    = psel_a;
  assign bus_a.penable = penable;
  assign bus_a.pwrite  = pwrite;
  assign bus_a.paddr   = paddr;
  assign bus_a.pwdata  = pwdata;
  assign bus_b.hclk    = clk;
  assign bus_b.hresetn = rst_b_n;
  assign bus_b.psel    = psel_b;
  assign bus_b.penable = penable;
  assign bus_b.pwrite  = pwrite;
  assign bus_b.paddr   = paddr;
  assign bus_b.pwdata  = pwdata;

  apb4_gpio_ext dut_a (
    .apb4          (bus_a),
    .gpio_in_i     (gin_a),
    .gpio_in_sync_o(sync_a),
    .gpio_out_o    (out_a),
    .gpio_dir_o    (dir_a),
    .gpio_iof_o    (iof_a),
    .irq_o         (irq_a)
  );

  apb4_gpio_ext #(.GPIO_NUM(8)) dut_b (
    .apb4          (bus_b),
    .gpio_in_i     (gin_b),
    .gpio_in_sync_o(sync_b),
    .gpio_out_o    (out_b),
    .gpio_dir_o    (dir_b),
    .gpio_iof_o    (iof_b),
    .irq_o         (irq_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic sel_b, input logic [5:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    psel_a = !sel_b; psel_b = sel_b; pwrite = 1'b1; penable = 1'b0;
    paddr = {26'b0, addr}; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic sel_b, input logic [5:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    psel_a = !sel_b; psel_b = sel_b; pwrite = 1'b0; penable = 1'b0;
    paddr = {26'b0, addr};
    @(posedge clk); #1;
    penable = 1'b1;
    #1 data = sel_b ? bus_b.prdata : bus_a.prdata;
    @(posedge clk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  function automatic void add(input logic wr, input logic [5:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gin_a = '0; gin_b = '0;

    for (int a = 0; a < 16; a++) add(1'b0, 6'(a * 4), 32'h0, 32'h0);
    add(1, 6'h08, 32'h0000_00F0, 0);
    add(1, 6'h0C, 32'h0000_0001, 0);
    add(1, 6'h10, 32'h0000_0010, 0);
    add(1, 6'h14, 32'h0000_0300, 0);
    add(0, 6'h08, 0, 32'h0000_03E1);
    add(0, 6'h0C, 0, 32'h0);
    add(0, 6'h10, 0, 32'h0);
    add(0, 6'h14, 0, 32'h0);
    add(1, 6'h00, 32'hA5A5_5A5A, 0);
    add(0, 6'h00, 0, 32'hA5A5_5A5A);
    add(1, 6'h28, 32'h1234_5678, 0);
    add(0, 6'h28, 0, 32'h1234_5678);
    add(1, 6'h30, 32'h0001_2345, 0);
    add(0, 6'h30, 0, 32'h0000_2345);
    add(1, 6'h30, 32'h0, 0);
    add(1, 6'h1C, 32'hFFFF_0000, 0);
    add(0, 6'h1C, 0, 32'hFFFF_0000);
    add(1, 6'h1C, 32'h0, 0);
    add(1, 6'h20, 32'h0F0F_0F0F, 0);
    add(0, 6'h20, 0, 32'h0F0F_0F0F);
    add(1, 6'h20, 32'h0, 0);
    add(1, 6'h18, 32'h8000_0001, 0);
    add(0, 6'h18, 0, 32'h8000_0001);
    add(1, 6'h18, 32'h0, 0);
    add(1, 6'h2C, 32'hFFFF_FFFF, 0);
    add(0, 6'h2C, 0, 32'hFFFF_FFFF);
    add(1, 6'h2C, 32'h0, 0);
    add(1, 6'h24, 32'hFFFF_FFFF, 0);
    add(0, 6'h24, 0, 32'h0);
    add(1, 6'h04, 32'hFFFF_FFFF, 0);
    add(0, 6'h04, 0, 32'h0);
    add(1, 6'h38, 32'hFFFF_FFFF, 0);
    add(0, 6'h38, 0, 32'h0);

    repeat (3) @(posedge clk);
    #1 rst_a_n = 1'b1; rst_b_n = 1'b1;
    check("reset_irq", {31'b0, irq_a}, 32'h0);
    check("reset_out", out_a, 32'h0);
    check("reset_sync", sync_a, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        apb_write(1'b0, vecs[i].addr, vecs[i].data);
      end else begin
        apb_read(1'b0, vecs[i].addr, rd);
        check($sformatf("vec%0d@%02h", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end
    check("out_pins", out_a, 32'h0000_03E1);
    check("dir_pins", dir_a, 32'hA5A5_5A5A);
    check("iof_pins", iof_a, 32'h1234_5678);

    apb_write(1'b0, 6'h14, 32'h0000_0300);
    check("out_after_tgl", out_a, 32'h0000_00E1);

    apb_write(1'b0, 6'h2C, 32'h1);
    apb_write(1'b0, 6'h30, 32'h0);
    @(posedge clk); #1 gin_a[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 gin_a[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (sync_a[0]) seen = 1'b1;
    end
    check("glitch_rejected", {31'b0, seen}, 32'h0);

    @(posedge clk); #1 gin_a[0] = 1'b1; gin_a[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("dbnc_pin0_k%0d", k), {31'b0, sync_a[0]}, 32'(k >= 7));
      check($sformatf("raw_pin0_k%0d", k), {31'b0, dut_a.raw_sync[0]}, 32'(k >= 2));
      check($sformatf("direct_pin3_k%0d", k), {31'b0, sync_a[3]}, 32'(k >= 3));
    end
    apb_read(1'b0, 6'h34, rd); check("rawin", rd, 32'h9);
    apb_read(1'b0, 6'h04, rd); check("padin", rd, 32'h9);

    apb_write(1'b0, 6'h30, 32'h1);
    @(posedge clk); #1 gin_a[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 7) check("div1_hold", {31'b0, sync_a[0]}, 32'h1);
      if (k == 16) check("div1_done", {31'b0, sync_a[0]}, 32'h0);
    end
    apb_write(1'b0, 6'h30, 32'h0);

    apb_write(1'b0, 6'h18, 32'h2);
    @(posedge clk); #1 gin_a[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("rise_irq_k%0d", k), {31'b0, irq_a}, 32'(k >= 5));
    end
    apb_read(1'b0, 6'h24, rd); check("rise_stat", rd, 32'h2);
    apb_write(1'b0, 6'h24, 32'h2);
    check("irq_hold_w1c_edge", {31'b0, irq_a}, 32'h1);
    @(posedge clk); #1;
    check("irq_drop_after_w1c", {31'b0, irq_a}, 32'h0);
    apb_read(1'b0, 6'h24, rd); check("stat_cleared", rd, 32'h0);

    apb_write(1'b0, 6'h20, 32'h4);
    @(posedge clk); #1 gin_a[2] = 1'b1;
    repeat (6) @(posedge clk);
    apb_write(1'b0, 6'h18, 32'h4);
    repeat (2) @(posedge clk);
    #1 check("level_irq", {31'b0, irq_a}, 32'h1);
    apb_write(1'b0, 6'h24, 32'h4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("level_reset_k%0d", k), {31'b0, irq_a}, 32'h1);
    end
    apb_read(1'b0, 6'h24, rd); check("level_stat", rd, 32'h4);
    apb_write(1'b0, 6'h18, 32'h0);
    @(posedge clk); #1;
    check("inten_off_irq", {31'b0, irq_a}, 32'h0);
    apb_read(1'b0, 6'h24, rd); check("inten_off_sticky", rd, 32'h4);
    gin_a[2] = 1'b0;
    repeat (6) @(posedge clk);
    apb_write(1'b0, 6'h18, 32'h4);
    repeat (2) @(posedge clk);
    #1 check("reenable_irq", {31'b0, irq_a}, 32'h1);
    apb_write(1'b0, 6'h24, 32'h4);
    @(posedge clk); #1;
    check("level_gone_irq", {31'b0, irq_a}, 32'h0);
    apb_read(1'b0, 6'h24, rd); check("level_gone_stat", rd, 32'h0);

    apb_write(1'b0, 6'h1C, 32'h2);
    apb_write(1'b0, 6'h18, 32'h2);
    @(posedge clk); #1 gin_a[1] = 1'b0;
    repeat (6) @(posedge clk);
    apb_read(1'b0, 6'h24, rd); check("fall_stat", rd, 32'h2);
    check("fall_irq", {31'b0, irq_a}, 32'h1);

    apb_write(1'b1, 6'h00, 32'hFFFF_FFFF);
    apb_read(1'b1, 6'h00, rd); check("b_paddir", rd, 32'h0000_00FF);
    check("b_dir_pins", {24'b0, dir_b}, 32'h0000_00FF);
    apb_write(1'b1, 6'h08, 32'h0000_ABCD);
    apb_read(1'b1, 6'h08, rd); check("b_padout", rd, 32'h0000_00CD);
    apb_write(1'b1, 6'h2C, 32'h1);
    apb_write(1'b1, 6'h30, 32'h0);
    @(posedge clk); #1 gin_b[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("b_filt_high", {24'b0, sync_b}, 32'h1);
    gin_b[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("b_cnt_mid", 32'(dut_b.g_pin[0].u_dbnc.cnt), 32'h2);
    #2 rst_b_n = 1'b0;
    #1;
    check("b_async_filt", {24'b0, sync_b}, 32'h0);
    check("b_async_cnt", 32'(dut_b.g_pin[0].u_dbnc.cnt), 32'h0);
    check("b_async_dir", {24'b0, dir_b}, 32'h0);
    @(posedge clk); #1 rst_b_n = 1'b1;
    apb_read(1'b1, 6'h08, rd); check("b_padout_after_rst", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb4_gpio_ext.md
Name: apb4_gpio_ext

Overview:
Parametrised next-generation APB4 GPIO controller. Provides 1..32 pins with per-pin direction, output and IO-function select. Adds atomic set/clear/toggle output registers, a per-pin programmable debounce filter, and sticky per-pin interrupt status with write-1-to-clear. Sits on the peripheral APB4 bus and drives pad muxes and the interrupt controller.

Parameters:
GPIO_NUM, 32, number of pins (1..32); register bits >= GPIO_NUM read 0 and ignore writes.
DBNC_CNT, 4, debounce ticks a new level must hold before acceptance (>=1).
DIV_WIDTH, 16, width of the debounce prescaler register.

Ports:
apb4.hclk  input  1  clock, carried in apb4_if.
apb4.hresetn  input  1  reset, carried in apb4_if.
apb4  interface  apb4_if  APB4 slave: psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr.
gpio_in_i  input  GPIO_NUM  raw pad inputs, asynchronous.
gpio_in_sync_o  output  GPIO_NUM  filtered input.
gpio_out_o  output  GPIO_NUM  output value.
gpio_dir_o  output  GPIO_NUM  1 = output enable.
gpio_iof_o  output  GPIO_NUM  1 = alternate function.
irq_o  output  1  level interrupt.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (apb4.hresetn). Every register and output resets to 0, including irq_o.
- APB: pready=1 and pslverr=0 always. A write commits on psel&penable&pwrite. Decode uses paddr[5:2]. Unmapped addresses read 0 and writes are ignored.
- Register map (byte offset):
  - 0x00 PADDIR rw
  - 0x04 PADIN ro: filtered input
  - 0x08 PADOUT rw
  - 0x0C OUTSET wo: PADOUT |= wdata
  - 0x10 OUTCLR wo: PADOUT &= ~wdata
  - 0x14 OUTTGL wo: PADOUT ^= wdata
  - 0x18 INTEN rw
  - 0x1C INTTYPE0 rw
  - 0x20 INTTYPE1 rw
  - 0x24 INTSTAT rw1c
  - 0x28 IOFCFG rw
  - 0x2C DBNCEN rw
  - 0x30 DBNCDIV rw: DIV_WIDTH bits
  - 0x34 RAWIN ro: synchroniser output
  - Write-only registers (OUTSET, OUTCLR, OUTTGL) read 0.
- Input path: 2-flop synchroniser produces raw_sync, followed by filter register filt.
  - DBNCEN bit = 0: filt <= raw_sync each cycle. PADIN changes 3 cycles after a pad change.
  - DBNCEN bit = 1: a per-pin counter clears while raw_sync==filt. It increments on each prescaler tick while raw_sync!=filt. When the count reaches DBNC_CNT on a tick, filt <= raw_sync and the counter clears.
  - A glitch shorter than the hold time leaves filt unchanged.
- Prescaler: a free-running counter issues a one-cycle tick and reloads when it reaches DBNCDIV. DBNCDIV=0 gives a tick every cycle. Writing DBNCDIV restarts the counter at 0.
- Edge detection: filt_d is filt delayed 1 cycle.
  - rise = filt & ~filt_d
  - fall = ~filt & filt_d
- Interrupt type, encoded {INTTYPE1, INTTYPE0}:
  - 00: rise
  - 01: fall
  - 10: level high
  - 11: level low
- Status: INTSTAT[i] sets on the cycle after the event when INTEN[i]=1. Disabled pins never set status. Status bits are sticky.
- Status clear: a write of 1 to INTSTAT[i] clears the bit. If set and clear occur in the same cycle, set wins. For level types, status re-sets every cycle while the level persists.
- irq_o: registered, irq_o <= |(INTSTAT & INTEN). It asserts 1 cycle after a status bit sets. Clearing INTEN drops irq_o without clearing INTSTAT.
- Outputs: gpio_out_o = PADOUT, gpio_dir_o = PADDIR, gpio_iof_o = IOFCFG, gpio_in_sync_o = filt.
- Reset mid-debounce: counters and filt return to 0 immediately.
- Width: pwdata bits above GPIO_NUM are dropped. The prescaler and counters saturate at their compare values and never wrap past them.

Decomposition:
- Package apb4_gpio_ext_pkg:
  - register offset localparams
  - interrupt-type encoding typedef enum logic [1:0] {INT_RISE, INT_FALL, INT_HIGH, INT_LOW}
- Sub-module gpio_dbnc: one pin's counter and filter, with inputs clk, rst_n, tick, en, d and output q. It is instantiated GPIO_NUM times in a generate loop. The prescaler stays in the top level.

Test Plan:
- Reset, then read all registers -> all 0; irq_o=0; OUTSET/OUTCLR/OUTTGL read 0.
- Write PADOUT=0x0000_00F0, OUTSET=0x1, OUTCLR=0x10, OUTTGL=0x300 -> PADOUT=0x0000_03E1, gpio_out_o matches the cycle after the last write.
- DBNCEN=0x1, DBNCDIV=0, DBNC_CNT=4; pin0 high for 3 cycles then low -> PADIN[0] stays 0. Hold pin0 high 10 cycles -> PADIN[0]=1 at 2+4+1 cycles after the edge; RAWIN[0]=1 after 2.
- INTEN=0x2, type 00 on pin1, rising pin1 -> INTSTAT=0x2, irq_o=1. W1C 0x2 -> INTSTAT=0, irq_o=0 the next cycle.
- Pin2 type 10 held high, INTEN=0x4, W1C INTSTAT 0x4 -> bit re-sets the next cycle, irq_o stays 1. Drive pin2 low then W1C -> irq_o=0.
- GPIO_NUM=8 build: write PADDIR=0xFFFF_FFFF -> reads 0x0000_00FF. Assert hresetn low mid-debounce -> filt and counters reach 0 asynchronously.
